restoring_divider: RTL and testbench

Sequential unsigned restoring divider. It is the inverse companion of the combinational array multiplier. It takes a WIDTH-bit dividend and divisor through a start/done handshake and produces the quotient and remainder after WIDTH iterations, one shift-subtract per clock. It sits beside the multiplier behind the Tiny Tapeout top level. A host can check that multiplier product / multiplicand returns the multiplier and remainder 0.

---
 rtl/restoring_divider.sv | 131 +++++++++++++
 tb/tb_restoring_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one shift-subtract per clock
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   t_sub;
    logic             t_ge;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH:0]   r_next;

    assign t_val  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign t_sub  = t_val - {1'b0, d_q};
    assign t_ge   = (t_val >= {1'b0, d_q});
    assign q_next = {q_q[WIDTH-2:0], t_ge};
    assign r_next = t_ge ? t_sub : t_val;

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        dz_d        = dz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    dz_d    = (divisor == '0);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (dz_q) begin
                    // Divide by zero skips iterations; Q still holds the dividend.
                    quotient_d  = '1;
                    remainder_d = q_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    dz_d        = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    q_d   = q_next;
                    r_d   = r_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        quotient_d  = q_next;
                        remainder_d = r_next[WIDTH-1:0];
                        dbz_d       = 1'b0;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - scoreboard bench for restoring_divider, WIDTH=4
module tb_restoring_divider;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Array multiplier reference: sum of shifted partial-product rows.
    function automatic int array_mult(input logic [W-1:0] x, input logic [W-1:0] y);
        int acc = 0;
        for (int i = 0; i < W; i++)
            if (y[i]) acc += int'(x) << i;
        return acc;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected result and compare against the outputs now visible.
    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_quotient"}, quotient, e.q);
        chk({tag, "_remainder"}, remainder, e.r);
        chk({tag, "_dbz"}, div_by_zero, e.dz);
        if (e.b != 0) begin
            chk({tag, "_mult_inv"}, array_mult(quotient, e.b) + int'(remainder), e.a);
            chk({tag, "_rem_lt"}, remainder < e.b, 32'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        bit busy_gap = 0;
        start = 1'b1; dividend = a; divisor = b;
        sb.push_back(model(a, b));
        tick();
        start = 1'b0; dividend = $urandom_range(15); divisor = $urandom_range(15);
        chk({tag, "_busy_after_accept"}, busy, 32'd1);
        for (lat = 1; lat <= 12; lat++) begin
            tick();
            if (done) break;
            if (!busy) busy_gap = 1;
        end
        chk({tag, "_latency"}, lat, (b == 0) ? 32'd1 : 32'd4);
        chk({tag, "_busy_held"}, busy_gap, 32'd0);
        chk({tag, "_busy_at_done"}, busy, 32'd0);
        check_result(tag);
        tick();
        chk({tag, "_done_pulse"}, done, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        tick();

        run_op("basic_13_3", 4'd13, 4'd3);
        run_op("b_15_1", 4'd15, 4'd1);
        run_op("b_0_7", 4'd0, 4'd7);
        run_op("b_6_7", 4'd6, 4'd7);
        run_op("b_15_15", 4'd15, 4'd15);
        run_op("dz_9_0", 4'd9, 4'd0);
        run_op("after_dz_8_2", 4'd8, 4'd2);

        // Second request at k+2 must be ignored while busy.
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        sb.push_back(model(4'd12, 4'd5));
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        tick();
        start = 1'b0;
        tick();
        chk("abuse_no_done_k3", done, 0);
        tick();
        chk("abuse_done_k4", done, 1);
        check_result("abuse");
        tick();
        chk("abuse_idle_busy", busy, 0);
        chk("abuse_idle_done", done, 0);

        // Start held high: one completion every WIDTH+1 cycles.
        start = 1'b1; dividend = 4'd11; divisor = 4'd2;
        tick();
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk($sformatf("b2b_done_%0d", i), done, (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_excl_%0d", i), busy & done, 0);
            if (done) begin
                chk($sformatf("b2b_q_%0d", i), quotient, 5);
                chk($sformatf("b2b_r_%0d", i), remainder, 1);
            end
        end
        start = 1'b0;
        tick();

        // Reset mid-operation discards the in-flight divide.
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_q", quotient, 0);
        chk("mrst_r", remainder, 0);
        chk("mrst_dbz", div_by_zero, 0);
        begin
            bit saw_done = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done) saw_done = 1;
            end
            chk("mrst_no_done", saw_done, 0);
        end
        run_op("after_rst_14_3", 4'd14, 4'd3);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op($sformatf("ex_%0d_%0d", a, b), 4'(a), 4'(b));

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
